// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write path.
// R0 is the hardwired zero register: writes to it are dropped and it is never pending.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int R0     = 0;

  typedef logic [ADDR_W-1:0] rf_addr_t;
  typedef logic [DATA_W-1:0] rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. last remembers the most recently granted port,
// so on a conflict the other port wins; grants are suppressed during reset.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req[0] && req[1]) begin
        gnt = last ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // last resets to 1 so port 0 wins the first conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RegFile write port between ALU (port 0) and load (port 1) writeback,
// registers the winning write and tracks per-register outstanding writes.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREGS  = rf_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W-1:0] rf_wa,
  output logic              rf_wen,
  output logic [DATA_W-1:0] rf_wd,
  output logic [NREGS-1:0]  pending
);

  // Handshake: a requester holds valid/addr/data stable until it sees ready;
  // a transfer happens at a rising edge where valid & ready, and ready is the
  // combinational grant (never depends on claim_*).
  logic [1:0]        gnt;
  logic              accept;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREGS-1:0]  pending_nxt;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign accept     = gnt[0] | gnt[1];

  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    if (gnt[1]) begin
      win_addr = req1_addr;
      win_data = req1_data;
    end
  end

  // R0 writes still consume the grant but never reach the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_wen <= 1'b0;
      rf_wa  <= '0;
      rf_wd  <= '0;
    end else if (accept) begin
      rf_wen <= (win_addr != ADDR_W'(R0));
      rf_wa  <= win_addr;
      rf_wd  <= win_data;
    end else begin
      rf_wen <= 1'b0;
    end
  end

  // Clear on commit first, then set on claim, so a new producer supersedes.
  always_comb begin
    pending_nxt = pending;
    if (rf_wen) begin
      pending_nxt[rf_wa] = 1'b0;
    end
    if (claim_valid && (claim_addr != ADDR_W'(R0))) begin
      pending_nxt[claim_addr] = 1'b1;
    end
    pending_nxt[R0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a cycle-level model predicts grants, outputs and
// pending bits; committed writes are matched against an expected queue.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int W = ADDR_W + DATA_W;

  logic           clock;
  logic           reset;
  logic           req0_valid, req1_valid, req0_ready, req1_ready;
  rf_addr_t       req0_addr, req1_addr, claim_addr, rf_wa;
  rf_data_t       req0_data, req1_data, rf_wd;
  logic           claim_valid, rf_wen;
  logic [NREGS-1:0] pending;

  logic [W-1:0]     exp_q[$];
  int               n_compared;
  int               n_mismatched;

  // model state
  logic             m_last, m_wen;
  rf_addr_t         m_wa;
  rf_data_t         m_wd;
  logic [NREGS-1:0] m_pend;

  rf_write_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rf_wa       (rf_wa),
    .rf_wen      (rf_wen),
    .rf_wd       (rf_wd),
    .pending     (pending)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // committed-write scoreboard
  always @(negedge clock) begin
    if (rf_wen === 1'b1) begin
      logic [W-1:0] exp_w;
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL commit_unexpected: got wa=%h wd=%h, required no write", rf_wa, rf_wd);
      end else begin
        exp_w = exp_q.pop_front();
        if ({rf_wa, rf_wd} !== exp_w) begin
          n_mismatched++;
          $display("FAIL commit: got wa=%h wd=%h, required wa=%h wd=%h",
                   rf_wa, rf_wd, exp_w[W-1:DATA_W], exp_w[DATA_W-1:0]);
        end
      end
    end
  end

  function automatic wb_req_t mk(input logic v, input rf_addr_t a, input rf_data_t d);
    wb_req_t r;
    r.valid = v;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  // driver: one clock of stimulus, starting and ending at a falling edge
  task automatic step(input wb_req_t r0, input wb_req_t r1, input logic cv, input rf_addr_t ca,
                      output logic g0, output logic g1);
    logic [NREGS-1:0] p;
    wb_req_t          win;
    req0_valid = r0.valid; req0_addr = r0.addr; req0_data = r0.data;
    req1_valid = r1.valid; req1_addr = r1.addr; req1_data = r1.data;
    claim_valid = cv; claim_addr = ca;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (r0.valid && r1.valid) begin
      if (m_last) g0 = 1'b1; else g1 = 1'b1;
    end else begin
      g0 = r0.valid;
      g1 = r1.valid;
    end
    n_compared++;
    if (req0_ready !== g0 || req1_ready !== g1) begin
      n_mismatched++;
      $display("FAIL ready: got %b%b, required %b%b (r1,r0)", req1_ready, req0_ready, g1, g0);
    end
    p = m_pend;
    if (m_wen) p[m_wa] = 1'b0;
    if (cv && ca != rf_addr_t'(R0)) p[ca] = 1'b1;
    if (g0 || g1) begin
      win    = g0 ? r0 : r1;
      m_wa   = win.addr;
      m_wd   = win.data;
      m_wen  = (win.addr != rf_addr_t'(R0));
      m_last = g1;
      if (m_wen) exp_q.push_back({win.addr, win.data});
    end else begin
      m_wen = 1'b0;
    end
    m_pend = p;
    @(posedge clock);
    @(negedge clock);
    n_compared++;
    if (rf_wen !== m_wen || rf_wa !== m_wa || rf_wd !== m_wd) begin
      n_mismatched++;
      $display("FAIL out_stage: got wen=%b wa=%h wd=%h, required wen=%b wa=%h wd=%h",
               rf_wen, rf_wa, rf_wd, m_wen, m_wa, m_wd);
    end
    n_compared++;
    if (pending !== m_pend) begin
      n_mismatched++;
      $display("FAIL pending: got %h, required %h", pending, m_pend);
    end
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) step(mk(0, 0, 0), mk(0, 0, 0), 1'b0, 0, g0, g1);
  endtask

  // holds reset for n cycles with the given requests presented
  task automatic do_reset(input int n, input wb_req_t r0, input wb_req_t r1);
    reset = 1'b1;
    req0_valid = r0.valid; req0_addr = r0.addr; req0_data = r0.data;
    req1_valid = r1.valid; req1_addr = r1.addr; req1_data = r1.data;
    claim_valid = 1'b1; claim_addr = 5'd12;
    for (int i = 0; i < n; i++) begin
      #1;
      n_compared++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_ready: got %b%b, required 00", req1_ready, req0_ready);
      end
      @(posedge clock);
      @(negedge clock);
      n_compared++;
      if (rf_wen !== 1'b0 || rf_wa !== '0 || rf_wd !== '0 || pending !== '0) begin
        n_mismatched++;
        $display("FAIL reset_state: got wen=%b wa=%h wd=%h pend=%h, required all 0",
                 rf_wen, rf_wa, rf_wd, pending);
      end
    end
    m_last = 1'b1; m_wen = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0;
    claim_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic g0, g1;
    do_reset(4, mk(1, 5'h01, 32'h1111), mk(1, 5'h02, 32'h2222));
    step(mk(1, 5'h01, 32'h1111), mk(1, 5'h02, 32'h2222), 1'b0, 0, g0, g1);
    n_compared++;
    if (g0 !== 1'b1 || req0_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL first_winner: got model_g0=%b, required port 0", g0);
    end
    step(mk(0, 0, 0), mk(1, 5'h02, 32'h2222), 1'b0, 0, g0, g1);
    idle(1);
  endtask

  task automatic test_single_write();
    logic g0, g1;
    step(mk(0, 0, 0), mk(0, 0, 0), 1'b1, 5'h0A, g0, g1);
    step(mk(1, 5'h0A, 32'hAA), mk(0, 0, 0), 1'b0, 0, g0, g1);
    n_compared++;
    if (rf_wen !== 1'b1 || rf_wa !== 5'h0A || rf_wd !== 32'hAA || pending[10] !== 1'b1) begin
      n_mismatched++;
      $display("FAIL single_write: got wen=%b wa=%h wd=%h p10=%b, required 1 0a aa 1",
               rf_wen, rf_wa, rf_wd, pending[10]);
    end
    idle(1);
    n_compared++;
    if (pending[10] !== 1'b0) begin
      n_mismatched++;
      $display("FAIL single_clear: got p10=%b, required 0", pending[10]);
    end
  endtask

  task automatic test_contention();
    logic g0, g1;
    do_reset(1, mk(0, 0, 0), mk(0, 0, 0));
    for (int i = 0; i < 4; i++)
      step(mk(1, 5'h03, 32'h33), mk(1, 5'h04, 32'h44), 1'b0, 0, g0, g1);
    idle(1);
  endtask

  task automatic test_r0();
    logic g0, g1;
    step(mk(0, 0, 0), mk(1, 5'h00, 32'hFFFF_FFFF), 1'b1, 5'h00, g0, g1);
    n_compared++;
    if (rf_wen !== 1'b0 || pending[0] !== 1'b0) begin
      n_mismatched++;
      $display("FAIL r0_drop: got wen=%b p0=%b, required 0 0", rf_wen, pending[0]);
    end
    step(mk(1, 5'h06, 32'h66), mk(1, 5'h08, 32'h88), 1'b0, 0, g0, g1);
    step(mk(0, 0, 0), mk(1, 5'h08, 32'h88), 1'b0, 0, g0, g1);
    idle(1);
  endtask

  task automatic test_collision();
    logic g0, g1;
    step(mk(0, 0, 0), mk(0, 0, 0), 1'b1, 5'h05, g0, g1);
    step(mk(1, 5'h05, 32'h55), mk(0, 0, 0), 1'b0, 0, g0, g1);
    step(mk(0, 0, 0), mk(0, 0, 0), 1'b1, 5'h05, g0, g1);
    n_compared++;
    if (pending[5] !== 1'b1) begin
      n_mismatched++;
      $display("FAIL collision: got p5=%b, required 1", pending[5]);
    end
    step(mk(0, 0, 0), mk(1, 5'h05, 32'h5555), 1'b0, 0, g0, g1);
    idle(2);
  endtask

  task automatic test_midflight_reset();
    logic g0, g1;
    step(mk(0, 0, 0), mk(0, 0, 0), 1'b1, 5'h07, g0, g1);
    step(mk(0, 0, 0), mk(0, 0, 0), 1'b1, 5'h0B, g0, g1);
    step(mk(1, 5'h07, 32'h77), mk(0, 0, 0), 1'b0, 0, g0, g1);
    n_compared++;
    if (rf_wen !== 1'b1 || rf_wa !== 5'h07 || rf_wd !== 32'h77) begin
      n_mismatched++;
      $display("FAIL reset_edge_value: got wen=%b wa=%h wd=%h, required 1 07 77",
               rf_wen, rf_wa, rf_wd);
    end
    do_reset(2, mk(1, 5'h09, 32'h99), mk(1, 5'h0C, 32'hCC));
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic    g0, g1, cv;
    wb_req_t r0, r1;
    r0 = mk(0, 0, 0);
    r1 = mk(0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (!r0.valid) r0 = mk(1'($urandom_range(0, 1)), rf_addr_t'($urandom_range(0, NREGS - 1)),
                             rf_data_t'($urandom()));
      if (!r1.valid) r1 = mk(1'($urandom_range(0, 1)), rf_addr_t'($urandom_range(0, NREGS - 1)),
                             rf_data_t'($urandom()));
      cv = ($urandom_range(0, 2) == 0);
      step(r0, r1, cv, rf_addr_t'($urandom_range(0, NREGS - 1)), g0, g1);
      if (g0) r0.valid = 1'b0;
      if (g1) r1.valid = 1'b0;
    end
    idle(2);
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    @(negedge clock);
    test_reset();
    test_single_write();
    test_contention();
    test_r0();
    test_collision();
    test_midflight_reset();
    test_back_to_back();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL leftover_writes: got %0d uncommitted, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the 32×32 register file (`RegFile`) between two writeback requesters: ALU writeback on port 0 and load writeback on port 1. Requesters use valid/ready handshakes and are arbitrated round-robin. The block registers the winning write onto `wa`/`wen`/`wd` of `RegFile`. It also keeps a per-register pending scoreboard, which issue logic uses to detect outstanding writes.

## Interface
- `DATA_W`, default 32, write data width
- `ADDR_W`, default 5, register address width
- `NREGS`, default 32, number of registers (2**ADDR_W)

Ports:
- `clock` in 1: single clock; all state updates on its rising edge
- `reset` in 1: synchronous, active-high
- `req0_valid` in 1: ALU writeback request
- `req0_addr` in ADDR_W: ALU destination register
- `req0_data` in DATA_W: ALU result
- `req0_ready` out 1: port 0 accepted this cycle
- `req1_valid` in 1: load writeback request
- `req1_addr` in ADDR_W: load destination register
- `req1_data` in DATA_W: load result
- `req1_ready` out 1: port 1 accepted this cycle
- `claim_valid` in 1: issue logic reserves a destination register
- `claim_addr` in ADDR_W: register being reserved
- `rf_wa` out ADDR_W: to `RegFile` `wa`
- `rf_wen` out 1: to `RegFile` `wen`
- `rf_wd` out DATA_W: to `RegFile` `wd`
- `pending` out NREGS: bit i set means register i has an outstanding write

## Operation
- **Arbitration:** one grant per cycle. `reqN_ready` is combinational and equals grantN.
  - Single valid request: it is granted.
  - Both valid: the port not granted most recently wins.
  - The `last` pointer updates only on a grant. It resets to 1, so port 0 wins the first conflict.
- **Requester rules:** a requester holds `valid`/`addr`/`data` stable until it sees `ready`. Acceptance = `valid & ready` at a rising edge.
- **Output stage:**
  - On acceptance, the edge loads `rf_wa`/`rf_wd` with the granted addr/data.
  - `rf_wen` is set to 1 unless addr==0. Writes to R0 are accepted, consume the grant and update `last`, but are dropped with `rf_wen`=0.
  - With no acceptance, `rf_wen`=0 and `rf_wa`/`rf_wd` hold their values.
- **Scoreboard:**
  - `claim_valid` with `claim_addr`≠0 sets `pending[claim_addr]`.
  - An edge at which `rf_wen`=1 clears `pending[rf_wa]`.
  - Same register set and cleared in the same cycle: set wins (a new producer supersedes).
  - `pending[0]` is constantly 0; claims of R0 are ignored.
  - Writes to non-pending registers are legal and leave `pending` unchanged.
- **Reset values:**
  - `rf_wen`=0, `rf_wa`=0, `rf_wd`=0, `pending`=0, `last`=1.
  - Both `ready` outputs are forced 0 while `reset`=1.
- **Reset mid-operation:** a write registered in the output stage is discarded (`rf_wen`=0 after the reset edge). All pending bits clear. Requests presented during reset are not accepted.

## Timing
- Acceptance at edge E0 puts `rf_wen`/`rf_wa`/`rf_wd` valid from E0 to E1.
- `RegFile` commits at E1; the pending bit reads 0 after E1.
- Latency from acceptance to commit is 1 cycle. Throughput is 1 write per cycle, with no bubbles between back-to-back grants.
- Under continuous contention, each port gets exactly every other cycle. Maximum wait for a held request is 1 cycle.
- A `claim` at edge Ec makes `pending` visible after Ec.
- No combinational path from `claim_*` to `ready`. A combinational path from `reqN_valid` to `reqN_ready` is allowed.

## Structure
- Shared package `rf_pkg`:
  - `DATA_W`, `ADDR_W`, `NREGS`
  - `R0 = 0`
  - typedef `rf_addr_t` (ADDR_W bits), `rf_data_t` (DATA_W bits)
  - typedef `wb_req_t` {valid, addr, data}
- One sub-module, `rr_arb2`: 2-way round-robin arbiter holding the `last` flop. Inputs `clock`, `reset`, `req[1:0]`; output one-hot `gnt[1:0]`.
- Output register and scoreboard live in `rf_write_arbiter`.

## Test plan
- **Reset:** hold `reset` 4 cycles with both ports valid → `rf_wen`=0, `pending`=0, `ready`=0 throughout. Release → port 0 wins first.
- **Single write:** `claim` addr 0x0A, then req0 addr 0x0A data 0xAA → `rf_wen`=1, `rf_wa`=0x0A, `rf_wd`=0xAA one cycle after acceptance. `pending[10]` is 1 until that commit edge, then 0.
- **Contention:** both ports valid for 4 cycles, addrs 0x03/0x04, data 0x33/0x44 → commits alternate 0x03, 0x04, 0x03, 0x04 with no gap.
- **R0:** req1 addr 0, data 0xFFFF_FFFF → `req1_ready`=1, `rf_wen` stays 0. A subsequent conflict is granted to port 0.
- **Set/clear collision:** `pending[5]`=1; commit to R5 and `claim` R5 in the same cycle → `pending[5]` remains 1.
- **Mid-flight reset:** assert `reset` in the cycle `rf_wen`=1 for R7 → `rf_wen`=0 after the reset edge and `pending` all 0. `RegFile` R7 is written only if `rf_wen` was already sampled at that edge; the bench checks the reset-edge value explicitly.
